// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package rr_bus_arbiter_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Channel index width; never narrower than one bit so a 2..N channel
  // build always has a usable index.
  function automatic int ch_w_f(input int n_ch);
    return (n_ch > 2) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr, searching upward with wrap-around.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt_oh,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  localparam logic [CH_W:0] N_CH_W = (CH_W+1)'(N_CH);

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic [CH_W-1:0]   off;
  logic [CH_W:0]     sum;
  logic              found;

  // Rotate the doubled request vector so ptr lands at bit 0, take the lowest
  // set bit as an offset, then rotate the offset back to a channel index.
  always_comb begin
    req_dbl = {req, req};
    req_rot = N_CH'(req_dbl >> ptr);
    any     = |req;
    off     = '0;
    found   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (req_rot[i] && !found) begin
        found = 1'b1;
        off   = CH_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_CH_W) sum = sum - N_CH_W;
    idx    = sum[CH_W-1:0];
    gnt_oh = '0;
    if (any) gnt_oh[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// N-channel round-robin arbiter merging valid/ready streams onto one bus,
// with optional packet locking and a registered output stage.
module rr_bus_arbiter
  import rr_bus_arbiter_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 32,
  parameter bit PKT_LOCK = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CH-1:0]               ch_en,
  input  logic [N_CH-1:0]               ch_valid,
  input  logic [N_CH-1:0][DATA_W-1:0]   ch_data,
  input  logic [N_CH-1:0]               ch_last,
  output logic [N_CH-1:0]               ch_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_last,
  output logic [ch_w_f(N_CH)-1:0]       out_chan,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int              CH_W    = ch_w_f(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  arb_state_t        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [N_CH-1:0]   grant_oh_q, grant_oh_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [CH_W-1:0]   out_chan_q, out_chan_d;

  logic [N_CH-1:0]   pick_oh;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;
  logic              out_free;
  logic              beat_acc;
  logic              pkt_end;

  // Only enabled, valid channels compete; the enable mask matters only here.
  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .req    (ch_valid & ch_en),
    .ptr    (rr_ptr_q),
    .gnt_oh (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Ready for the locked channel only, whenever the output register can take
  // a beat; the one-hot grant keeps ch_data out of this path entirely.
  always_comb begin
    out_free = ~out_valid_q | out_ready;
    ch_ready = '0;
    if (state_q == LOCK) ch_ready = grant_oh_q & ch_valid & {N_CH{out_free}};
    beat_acc = |ch_ready;
    pkt_end  = beat_acc & (ch_last[grant_q] | ~PKT_LOCK);
  end

  // Arbitration FSM plus output-stage load/drain.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    case (state_q)
      ARB: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          grant_oh_d = pick_oh;
          state_d    = LOCK;
        end
      end
      LOCK: begin
        // A new beat overrides the drain, so load-and-drain keeps out_valid.
        if (beat_acc) begin
          out_valid_d = 1'b1;
          out_data_d  = ch_data[grant_q];
          out_last_d  = ch_last[grant_q];
          out_chan_d  = grant_q;
        end
        if (pkt_end) begin
          rr_ptr_d = (grant_q == LAST_CH) ? '0 : grant_q + CH_W'(1);
          state_d  = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State, grant, pointer and output registers; reset drops any partial packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;
  assign busy      = (state_q == LOCK);

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench for rr_bus_arbiter: a packet-lock build and a per-beat
// build share one driver and one monitor, selected by `mode`.
module tb_rr_bus_arbiter;

  localparam int N_CH   = 4;
  localparam int DATA_W = 32;
  localparam int CH_W   = 2;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
  } beat_t;

  typedef struct packed {
    logic [CH_W-1:0]   c;
    logic [DATA_W-1:0] d;
    logic              l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        reset;
  logic                        mode;
  logic [N_CH-1:0]             ch_en, ch_valid, ch_last, ch_ready;
  logic [N_CH-1:0][DATA_W-1:0] ch_data;
  logic                        out_ready;
  logic                        out_valid, out_last, busy;
  logic [DATA_W-1:0]           out_data;
  logic [CH_W-1:0]             out_chan;

  logic [N_CH-1:0]   v_a, v_b, rdy_a, rdy_b;
  logic              ov_a, ov_b, ol_a, ol_b, busy_a, busy_b;
  logic [DATA_W-1:0] od_a, od_b;
  logic [CH_W-1:0]   oc_a, oc_b;

  assign v_a       = mode ? '0 : ch_valid;
  assign v_b       = mode ? ch_valid : '0;
  assign ch_ready  = mode ? rdy_b : rdy_a;
  assign out_valid = mode ? ov_b : ov_a;
  assign out_data  = mode ? od_b : od_a;
  assign out_last  = mode ? ol_b : ol_a;
  assign out_chan  = mode ? oc_b : oc_a;
  assign busy      = mode ? busy_b : busy_a;

  rr_bus_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .PKT_LOCK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .ch_en(ch_en), .ch_valid(v_a), .ch_data(ch_data),
    .ch_last(ch_last), .ch_ready(rdy_a), .out_valid(ov_a), .out_data(od_a),
    .out_last(ol_a), .out_chan(oc_a), .out_ready(out_ready), .busy(busy_a)
  );

  rr_bus_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .PKT_LOCK(1'b0)) dut_b (
    .clk(clk), .reset(reset), .ch_en(ch_en), .ch_valid(v_b), .ch_data(ch_data),
    .ch_last(ch_last), .ch_ready(rdy_b), .out_valid(ov_b), .out_data(od_b),
    .out_last(ol_b), .out_chan(oc_b), .out_ready(out_ready), .busy(busy_b)
  );

  beat_t drv_q [N_CH][$];
  exp_t  exp_q [$];
  bit    rdy_q [$];
  bit    rnd_rdy;
  logic [N_CH-1:0] acc_prev;
  int    n_vec, n_bad;
  int    cyc, first_cyc, last_cyc;

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present the head of each channel queue and the next out_ready value.
  task automatic drive();
    for (int c = 0; c < N_CH; c++) begin
      ch_valid[c] = (drv_q[c].size() != 0);
      ch_data[c]  = (drv_q[c].size() != 0) ? drv_q[c][0].d : '0;
      ch_last[c]  = (drv_q[c].size() != 0) ? drv_q[c][0].l : 1'b0;
    end
    if (rdy_q.size() != 0) out_ready = rdy_q.pop_front();
    else out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // One clock: note handshakes before the edge, retire accepted beats after it.
  task automatic step();
    logic [N_CH-1:0] acc;
    @(negedge clk);
    acc = ch_valid & ch_ready;
    @(posedge clk);
    #1;
    acc_prev = acc;
    for (int c = 0; c < N_CH; c++) if (acc[c]) drv_q[c].delete(0);
    drive();
  endtask

  task automatic do_reset(input bit m);
    reset = 1'b1;
    mode  = m;
    for (int c = 0; c < N_CH; c++) drv_q[c].delete();
    exp_q.delete();
    rdy_q.delete();
    rnd_rdy = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load_pkt(input int c, input int len, input logic [DATA_W-1:0] base,
                          input bit rnd, input bit push_exp);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = rnd ? DATA_W'($urandom) : base + DATA_W'(i);
      b.l = (i == len - 1);
      drv_q[c].push_back(b);
      if (push_exp) exp_q.push_back({CH_W'(c), b.d, b.l});
    end
  endtask

  // Reference order: every enabled channel keeps its queue valid, so service
  // is plain round-robin over channels that still have beats, starting at 0.
  task automatic model(input logic [N_CH-1:0] en, input bit plock);
    int idx [N_CH];
    int ptr, pick;
    bit more, done;
    beat_t b;
    for (int c = 0; c < N_CH; c++) idx[c] = 0;
    ptr  = 0;
    more = 1'b1;
    while (more) begin
      pick = -1;
      for (int k = 0; k < N_CH; k++) begin
        int c;
        c = (ptr + k) % N_CH;
        if (pick < 0 && en[c] && idx[c] < drv_q[c].size()) pick = c;
      end
      if (pick < 0) more = 1'b0;
      else begin
        done = 1'b0;
        while (!done) begin
          b = drv_q[pick][idx[pick]];
          idx[pick]++;
          exp_q.push_back({CH_W'(pick), b.d, b.l});
          done = plock ? b.l : 1'b1;
        end
        ptr = (pick + 1) % N_CH;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (8) step();
  endtask

  task automatic wait_accept(input int c);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_prev[c] && n < 200);
    chk("accept_seen", acc_prev[c], 1);
  endtask

  task automatic rand_phase(input logic [N_CH-1:0] en, input bit m, input int npk,
                            input int len, input bit rr);
    do_reset(m);
    ch_en = en;
    for (int c = 0; c < N_CH; c++)
      for (int p = 0; p < npk; p++)
        load_pkt(c, (len > 0) ? len : $urandom_range(1, 4), '0, 1'b1, 1'b0);
    model(en, !m);
    rnd_rdy   = rr;
    first_cyc = -1;
    drive();
    drain();
  endtask

  // Monitor: pop the scoreboard on every output handshake and police stalls.
  initial begin : monitor
    bit          stall;
    logic [63:0] held;
    exp_t        e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (reset) stall = 1'b0;
      else begin
        if (stall) chk("hold_stable", {out_valid, out_chan, out_last, out_data}, held);
        if (ch_ready != '0) begin
          chk("ready_onehot", $countones(ch_ready), 1);
          chk("busy_when_ready", busy, 1);
        end
        if (out_valid && out_ready) begin
          chk("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", {out_chan, out_data, out_last}, {e.c, e.d, e.l});
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
          end
        end
        stall = out_valid && !out_ready;
        held  = {1'b1, out_chan, out_last, out_data};
      end
    end
  end

  initial begin : main
    n_vec = 0; n_bad = 0;
    reset = 1'b1; mode = 1'b0; ch_en = '0; ch_valid = '0; ch_last = '0;
    ch_data = '0; out_ready = 1'b0; rnd_rdy = 1'b0; acc_prev = '0;
    first_cyc = -1; last_cyc = 0;

    // Fairness: continuous 2-beat packets, one bubble between packets.
    rand_phase(4'b1111, 1'b0, 4, 2, 1'b0);
    chk("fair_span", last_cyc - first_cyc, 32 + 16 - 2);

    // Packet lock under contention.
    do_reset(1'b0);
    ch_en = 4'b1111;
    load_pkt(2, 5, 32'hA0, 1'b0, 1'b1);
    drive();
    wait_accept(2);
    load_pkt(0, 2, '0, 1'b1, 1'b1);
    drive();
    drain();

    // Backpressure on a channel-3 packet.
    do_reset(1'b0);
    ch_en = 4'b1111;
    drv_q[3].push_back({32'h11, 1'b0});
    drv_q[3].push_back({32'h22, 1'b0});
    drv_q[3].push_back({32'h33, 1'b1});
    exp_q.push_back({2'd3, 32'h11, 1'b0});
    exp_q.push_back({2'd3, 32'h22, 1'b0});
    exp_q.push_back({2'd3, 32'h33, 1'b1});
    rdy_q = '{1, 1, 1, 0, 0, 1, 0, 1};
    drive();
    drain();

    // Static enable mask.
    rand_phase(4'b1010, 1'b0, 3, 0, 1'b1);

    // Enable cleared mid-packet: packet completes, channel 1 not re-granted.
    do_reset(1'b0);
    ch_en = 4'b1010;
    load_pkt(1, 3, '0, 1'b1, 1'b1);
    load_pkt(1, 2, '0, 1'b1, 1'b0);
    load_pkt(3, 2, '0, 1'b1, 1'b1);
    load_pkt(3, 2, '0, 1'b1, 1'b1);
    drive();
    wait_accept(1);
    ch_en = 4'b1000;
    drain();

    // Reset in the middle of a channel-1 packet.
    do_reset(1'b0);
    ch_en = 4'b1111;
    load_pkt(1, 4, '0, 1'b1, 1'b0);
    exp_q.push_back({2'd1, drv_q[1][0].d, drv_q[1][0].l});
    drive();
    wait_accept(1);
    wait_accept(1);
    chk("pre_reset_drained", exp_q.size(), 0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_chan", out_chan, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ch_ready", ch_ready, 0);
    end
    @(posedge clk);
    #1;
    drv_q[1].delete();
    load_pkt(1, 4, '0, 1'b1, 1'b1);
    reset = 1'b0;
    drive();
    drain();

    // Random traffic on the packet-lock build.
    rand_phase(4'b1111, 1'b0, 5, 0, 1'b1);
    rand_phase(N_CH'($urandom), 1'b0, 4, 0, 1'b1);

    // Per-beat build: two 3-beat packets interleave, last passed through.
    do_reset(1'b1);
    ch_en = 4'b1111;
    load_pkt(0, 3, 32'hB0, 1'b0, 1'b0);
    load_pkt(1, 3, 32'hC0, 1'b0, 1'b0);
    model(4'b1111, 1'b0);
    drive();
    drain();
    rand_phase(N_CH'($urandom) | 4'b0001, 1'b1, 4, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Parametrised N-channel round-robin bus arbiter merging several valid/ready streams onto one shared bus with packet locking, per-channel enable masking and a registered output stage. It is the multi-channel successor to the single-link interface module: it sits between the channel producers and the shared bus consumer, under the same one-clock VUnit bench environment.

## Interface
- N_CH, 4: number of input channels, 2..16.
- DATA_W, 32: data width per beat, 8..256.
- PKT_LOCK, 1: 1 = hold grant until the `last` beat is accepted; 0 = re-arbitrate after every beat.
- CH_W, $clog2(N_CH): width of the channel index (derived, not overridden).

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ch_en  in  N_CH  per-channel enable mask, sampled only in ARB.
- ch_valid  in  N_CH  per-channel beat valid.
- ch_data  in  N_CH x DATA_W  per-channel beat data.
- ch_last  in  N_CH  per-channel end-of-packet marker.
- ch_ready  out  N_CH  per-channel accept; one-hot or zero.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  output beat data.
- out_last  out  1  output end-of-packet.
- out_chan  out  CH_W  source channel of the current output beat.
- out_ready  in  1  downstream accept.
- busy  out  1  high while in LOCK state.

## Operation
- States: ARB, LOCK.
- ARB:
  - Candidates are `ch_valid & ch_en`.
  - If any candidate exists, pick the first one at or after `rr_ptr`, searching upward with wrap from N_CH-1 to 0.
  - Register the pick as `grant`, then go to LOCK.
  - With no candidates, stay in ARB.
  - `ch_ready` is all-zero in ARB.
- LOCK:
  - `ch_ready[grant] = ch_valid[grant] & (~out_valid | out_ready)`; all other ready bits are 0.
  - On input acceptance, register data, last and grant into the output stage and set out_valid.
  - The packet ends when an accepted input beat has `ch_last` = 1, or on any accepted beat if PKT_LOCK = 0.
  - At packet end: set `rr_ptr = (grant + 1) mod N_CH` and go to ARB in the next cycle.
- Output stage:
  - out_valid clears when out_ready is high and no new beat is loaded in the same cycle.
  - out_data, out_last and out_chan are held stable while `out_valid & ~out_ready`.
- Channel enable:
  - Deasserting `ch_en[grant]` during LOCK does not abort the packet; the grant persists until `last`.
  - An idle `ch_valid[grant]` in LOCK simply stalls; there is no timeout.
- Reset (asynchronous, also mid-packet) forces:
  - state ARB, grant 0, rr_ptr 0;
  - out_valid 0, out_last 0, out_data 0, out_chan 0;
  - busy 0, ch_ready all 0.
- A partial packet interrupted by reset is dropped; no recovery is attempted.

## Timing
- Arbitration latency: a candidate valid in ARB at cycle t is granted at edge t.
  - The first beat can be accepted in cycle t+1.
  - out_valid is first high in cycle t+2.
- Throughput inside a packet: 1 beat/cycle while out_ready is held high.
- Packet turnaround: exactly one ARB bubble cycle between the last beat of one packet and the first beat of the next, even for the same channel.
- Backpressure: with out_valid = 1 and out_ready = 0, ch_ready goes low in the same cycle (combinational from out_ready). No beat is lost or duplicated.
- Simultaneous load and drain (out_valid & out_ready & input accept): the new beat replaces the old one, and out_valid stays 1.
- ch_ready is combinational from ch_valid, out_valid, out_ready and registered state only. There is no path from ch_data.

## Structure
- Package rr_bus_arbiter_pkg:
  - `arb_state_t` enum {ARB, LOCK};
  - a function computing CH_W from N_CH, with a minimum of 1.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any flag.
  - Built with a double-width mask-and-rotate, parametrised on N_CH.
- Top level: state register, grant/rr_ptr registers, output register stage, ready generation.

## Test plan
- Reset mid-packet:
  - Stimulus: channel 1 streams a 4-beat packet; reset is asserted after beat 2 for 3 cycles, then released.
  - Required: all outputs are 0 during reset; after release, ch_1 re-requests and gets a fresh grant; no stale beats appear.
- Fairness:
  - Stimulus: all 4 channels continuously valid with 2-beat packets, out_ready = 1.
  - Required: out_chan sequence 0,0,1,1,2,2,3,3,0,…, with one bubble between packets.
- Packet lock under contention:
  - Stimulus: channel 2 sends a 5-beat packet (data 0xA0..0xA4) while channel 0 requests at beat 1.
  - Required: all 5 A-beats are contiguous, then channel 0 is granted.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 during a channel 3 packet with data 0x11,0x22,0x33.
  - Required: out_data is held during stalls, and the output order is exactly 0x11,0x22,0x33.
- Enable mask:
  - Stimulus: ch_en = 4'b1010 with all channels valid.
  - Required: only channels 1 and 3 are granted.
  - Stimulus: clear ch_en[1] mid-packet.
  - Required: the packet completes, and channel 1 is not re-granted.
- PKT_LOCK = 0 build:
  - Stimulus: channels 0 and 1 each send 3-beat packets.
  - Required: beats interleave 0,1,0,1,0,1, with out_last passed through unchanged.
